// File: rtl/hovalaag_sequencer.sv
// hovalaag_sequencer: fetches host instructions by PC, slices them onto the Hovalaag wrapper's
// one-hot addr bus, refills IN1/IN2 and returns OUT1/OUT2. Define HOV_SEQ_DEBUG_EN for D0..D3 + dbg_*.
module hovalaag_sequencer #(
  parameter int RST_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic        abort,
  input  logic [7:0]  stop_pc,
  output logic        busy,
  output logic        done,
  output logic [7:0]  pc,
  input  logic [31:0] instr_data,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [11:0] in1_data,
  input  logic        in1_valid,
  output logic        in1_ready,
  input  logic [11:0] in2_data,
  input  logic        in2_valid,
  output logic        in2_ready,
  output logic [11:0] out_data,
  output logic        out_sel,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        hov_reset,
  output logic [9:0]  hov_addr,
  output logic [5:0]  hov_wdata,
  input  logic [7:0]  hov_rdata,
`ifdef HOV_SEQ_DEBUG_EN
  output logic [7:0]  dbg_a,
  output logic [7:0]  dbg_b,
  output logic [7:0]  dbg_c,
  output logic [7:0]  dbg_d,
`endif
  output logic [4:0]  fsm_state
);

  // Streams transfer on a rising edge where valid && ready; ready is high only in the consuming state.
  typedef enum logic [4:0] {
    S_IDLE, S_RST, S_W_IN1, S_W_IN2, S_A6, S_A7, S_A8, S_A9, S_PUSH, S_FETCH,
    S_L0, S_L1, S_L2, S_L3, S_L4, S_EXEC, S_D0, S_D1, S_D2, S_D3
  } state_t;

  localparam logic [7:0] RST_LAST = 8'(RST_CYCLES - 1);

  state_t      state_q, state_d;
  logic [7:0]  rst_cnt_q, rst_cnt_d;
  logic        prime_q, prime_d;
  logic        abort_q, abort_d;
  logic [31:0] instr_q, instr_d;
  logic [11:0] in1_sh_q, in1_sh_d;
  logic [11:0] in2_sh_q, in2_sh_d;
  logic [3:0]  status_q, status_d;
  logic [11:0] out_q, out_d;
  logic [7:0]  pc_q, pc_d;
  logic        done_d;
  logic        post_out;
  logic        bound;

  function automatic logic [9:0] addr_of(input state_t s);
    logic [9:0] a;
    case (s)
      S_L0, S_D0: a = 10'h001;
      S_L1, S_D1: a = 10'h002;
      S_L2, S_D2: a = 10'h004;
      S_L3, S_D3: a = 10'h008;
      S_L4:       a = 10'h010;
      S_EXEC:     a = 10'h020;
      S_A6:       a = 10'h040;
      S_A7:       a = 10'h080;
      S_A8:       a = 10'h100;
      S_A9:       a = 10'h200;
      default:    a = 10'h000;
    endcase
    return a;
  endfunction

  function automatic logic [5:0] wdata_of(input state_t s, input logic [31:0] ins,
                                          input logic [11:0] i1, input logic [11:0] i2);
    logic [5:0] w;
    case (s)
      S_L0, S_D0: w = ins[5:0];
      S_L1, S_D1: w = ins[11:6];
      S_L2, S_D2: w = ins[17:12];
      S_L3, S_D3: w = ins[23:18];
      S_L4:       w = ins[29:24];
      S_EXEC:     w = {4'b0000, ins[31:30]};
      S_A6:       w = i1[5:0];
      S_A7:       w = i1[11:6];
      S_A8:       w = i2[5:0];
      S_A9:       w = i2[11:6];
      default:    w = 6'd0;
    endcase
    return w;
  endfunction

  always_comb begin
    state_d   = state_q;
    rst_cnt_d = rst_cnt_q;
    prime_d   = prime_q;
    abort_d   = abort_q | abort;
    instr_d   = instr_q;
    in1_sh_d  = in1_sh_q;
    in2_sh_d  = in2_sh_q;
    status_d  = status_q;
    out_d     = out_q;
    pc_d      = pc_q;
    done_d    = 1'b0;
    post_out  = 1'b0;
    bound     = 1'b0;
    case (state_q)
      S_IDLE: begin
        abort_d = 1'b0;
        if (start) begin
          state_d   = S_RST;
          rst_cnt_d = 8'd0;
          prime_d   = 1'b1;
        end
      end
      S_RST: begin
        if (rst_cnt_q == RST_LAST) state_d = S_W_IN1;
        else rst_cnt_d = rst_cnt_q + 8'd1;
      end
      S_W_IN1: begin
        if (in1_valid) begin
          in1_sh_d = in1_data;
          state_d  = (status_q[1] || prime_q) ? S_W_IN2 : S_A6;
        end
      end
      S_W_IN2: begin
        if (in2_valid) begin
          in2_sh_d = in2_data;
          state_d  = S_A6;
        end
      end
      S_A6: begin
        pc_d    = hov_rdata;
        state_d = S_A7;
      end
      S_A7: begin
        out_d[7:0] = hov_rdata;
        state_d    = S_A8;
      end
      S_A8: begin
        out_d[11:8] = hov_rdata[3:0];
        state_d     = S_A9;
      end
      // A stale status from a previous run must not emit a result during the priming pass.
      S_A9: begin
        if (status_q[2] && !prime_q) state_d = S_PUSH;
        else post_out = 1'b1;
      end
      S_PUSH:  if (out_ready) post_out = 1'b1;
      S_FETCH: begin
        if (instr_valid) begin
          instr_d = instr_data;
          state_d = S_L0;
        end
      end
      S_L0: state_d = S_L1;
      S_L1: state_d = S_L2;
      S_L2: state_d = S_L3;
      S_L3: state_d = S_L4;
      S_L4: state_d = S_EXEC;
      S_EXEC: begin
        status_d = hov_rdata[3:0];
        if (hov_rdata[0])      state_d = S_W_IN1;
        else if (hov_rdata[1]) state_d = S_W_IN2;
        else                   state_d = S_A6;
      end
      S_D0: state_d = S_D1;
      S_D1: state_d = S_D2;
      S_D2: state_d = S_D3;
      S_D3: bound   = 1'b1;
      default: state_d = S_IDLE;
    endcase
    if (post_out) begin
`ifdef HOV_SEQ_DEBUG_EN
      state_d = S_D0;
`else
      bound = 1'b1;
`endif
    end
    // Step boundary: no cycle of its own, resolved on the edge leaving the last step state.
    if (bound) begin
      if (abort_q || abort || (!prime_q && (pc_q == stop_pc))) begin
        state_d = S_IDLE;
        done_d  = 1'b1;
        abort_d = 1'b0;
      end else begin
        state_d = S_FETCH;
        prime_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      rst_cnt_q   <= 8'd0;
      prime_q     <= 1'b0;
      abort_q     <= 1'b0;
      instr_q     <= 32'd0;
      in1_sh_q    <= 12'd0;
      in2_sh_q    <= 12'd0;
      status_q    <= 4'd0;
      out_q       <= 12'd0;
      pc_q        <= 8'd0;
      busy        <= 1'b0;
      done        <= 1'b0;
      instr_ready <= 1'b0;
      in1_ready   <= 1'b0;
      in2_ready   <= 1'b0;
      out_valid   <= 1'b0;
      hov_reset   <= 1'b0;
      hov_addr    <= 10'd0;
      hov_wdata   <= 6'd0;
`ifdef HOV_SEQ_DEBUG_EN
      dbg_a       <= 8'd0;
      dbg_b       <= 8'd0;
      dbg_c       <= 8'd0;
      dbg_d       <= 8'd0;
`endif
    end else begin
      state_q     <= state_d;
      rst_cnt_q   <= rst_cnt_d;
      prime_q     <= prime_d;
      abort_q     <= abort_d;
      instr_q     <= instr_d;
      in1_sh_q    <= in1_sh_d;
      in2_sh_q    <= in2_sh_d;
      status_q    <= status_d;
      out_q       <= out_d;
      pc_q        <= pc_d;
      busy        <= (state_d != S_IDLE);
      done        <= done_d;
      instr_ready <= (state_d == S_FETCH);
      in1_ready   <= (state_d == S_W_IN1);
      in2_ready   <= (state_d == S_W_IN2);
      out_valid   <= (state_d == S_PUSH);
      hov_reset   <= (state_d == S_RST);
      hov_addr    <= addr_of(state_d);
      hov_wdata   <= wdata_of(state_d, instr_d, in1_sh_d, in2_sh_d);
`ifdef HOV_SEQ_DEBUG_EN
      if (state_q == S_D0) dbg_a <= hov_rdata;
      if (state_q == S_D1) dbg_b <= hov_rdata;
      if (state_q == S_D2) dbg_c <= hov_rdata;
      if (state_q == S_D3) dbg_d <= hov_rdata;
`endif
    end
  end

  assign pc        = pc_q;
  assign out_data  = out_q;
  assign out_sel   = status_q[3];
  assign fsm_state = state_q;

endmodule

// File: tb/tb_hovalaag_sequencer.sv
// Bench for hovalaag_sequencer: a behavioural wrapper model (PC counter advanced on each execute,
// programmable status and result bytes) answers hov_rdata from the one-hot address.
`timescale 1ns/1ps
module tb_hovalaag_sequencer;
  localparam int W = 13;

  logic        clk = 1'b0;
  logic        reset_n, start, abort;
  logic [7:0]  stop_pc;
  logic        busy, done;
  logic [7:0]  pc;
  logic [31:0] instr_data;
  logic        instr_valid, instr_ready;
  logic [11:0] in1_data, in2_data;
  logic        in1_valid, in1_ready, in2_valid, in2_ready;
  logic [11:0] out_data;
  logic        out_sel, out_valid, out_ready;
  logic        hov_reset;
  logic [9:0]  hov_addr;
  logic [5:0]  hov_wdata;
  logic [7:0]  hov_rdata;
  logic [4:0]  fsm_state;
`ifdef HOV_SEQ_DEBUG_EN
  logic [7:0]  dbg_a, dbg_b, dbg_c, dbg_d;
`endif

  logic [W-1:0] exp_q[$];
  logic [5:0]   wd_q[$];
  logic [7:0]   pc_exp_q[$];
  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] model_pc = 8'd0;
  logic [3:0] exec_status;
  logic [7:0] res_lo;
  logic [3:0] res_hi;

  hovalaag_sequencer #(.RST_CYCLES(2)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .abort(abort), .stop_pc(stop_pc),
    .busy(busy), .done(done), .pc(pc),
    .instr_data(instr_data), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .in1_data(in1_data), .in1_valid(in1_valid), .in1_ready(in1_ready),
    .in2_data(in2_data), .in2_valid(in2_valid), .in2_ready(in2_ready),
    .out_data(out_data), .out_sel(out_sel), .out_valid(out_valid), .out_ready(out_ready),
    .hov_reset(hov_reset), .hov_addr(hov_addr), .hov_wdata(hov_wdata), .hov_rdata(hov_rdata),
`ifdef HOV_SEQ_DEBUG_EN
    .dbg_a(dbg_a), .dbg_b(dbg_b), .dbg_c(dbg_c), .dbg_d(dbg_d),
`endif
    .fsm_state(fsm_state)
  );

  // Clock / reset block
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (hov_reset) model_pc <= 8'd0;
    else if (hov_addr[5]) model_pc <= model_pc + 8'd1;
  end

  always_comb begin
    hov_rdata = 8'h00;
    if (hov_addr[5])      hov_rdata = {4'h0, exec_status};
    else if (hov_addr[6]) hov_rdata = model_pc;
    else if (hov_addr[7]) hov_rdata = res_lo;
    else if (hov_addr[8]) hov_rdata = {4'h0, res_hi};
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({busy, done, pc, instr_ready, in1_ready, in2_ready, out_valid, out_sel, out_data,
         hov_reset, hov_addr, hov_wdata} !== 43'd0) begin
      n_err++;
      $display("FAIL reset_outputs: got busy=%b done=%b pc=%h addr=%h wdata=%h out=%h want all 0",
               busy, done, pc, hov_addr, hov_wdata, out_data);
    end
    reset_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0) begin
      n_err++;
      $display("FAIL idle_busy: got %b want 0", busy);
    end
  endtask

  task automatic test_start_prime();
    int rst_cnt = 0;
    int ov = 0;
    int addr_busy = 0;
    logic [5:0] e;
    in1_data = 12'h123; in1_valid = 1'b1;
    in2_data = 12'h456; in2_valid = 1'b1;
    instr_valid = 1'b0; exec_status = 4'h0; stop_pc = 8'hFF;
    wd_q.push_back(6'h23); wd_q.push_back(6'h04); wd_q.push_back(6'h16); wd_q.push_back(6'h11);
    pulse_start();
    for (int i = 0; i < 40; i++) begin
      if (hov_reset) rst_cnt++;
      if (out_valid) ov++;
      if (hov_addr[9:6] != 4'd0) begin
        n_cmp++;
        if (wd_q.size() == 0) begin
          n_err++;
          $display("FAIL prime_wdata: got %h with no expected value left", hov_wdata);
        end else begin
          e = wd_q.pop_front();
          if (hov_wdata !== e) begin
            n_err++;
            $display("FAIL prime_wdata: addr=%h got %h want %h", hov_addr, hov_wdata, e);
          end
        end
      end
      if (instr_ready) break;
      @(negedge clk);
    end
    n_cmp++;
    if (instr_ready !== 1'b1) begin
      n_err++;
      $display("FAIL prime_fetch: got instr_ready=%b want 1 within 40 cycles", instr_ready);
    end
    n_cmp++;
    if (rst_cnt !== 2) begin
      n_err++;
      $display("FAIL prime_hov_reset_len: got %0d want 2", rst_cnt);
    end
    n_cmp++;
    if ({pc, ov[7:0], busy} !== {8'd0, 8'd0, 1'b1}) begin
      n_err++;
      $display("FAIL prime_state: got pc=%h out_valid_cycles=%0d busy=%b want pc=00 0 busy=1", pc, ov, busy);
    end
    n_cmp++;
    if (wd_q.size() !== 0) begin
      n_err++;
      $display("FAIL prime_wdata_count: got %0d left want 0", wd_q.size());
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (hov_addr != 10'd0) addr_busy++;
    end
    n_cmp++;
    if (addr_busy !== 0) begin
      n_err++;
      $display("FAIL fetch_stall_addr: got %0d nonzero addr cycles want 0", addr_busy);
    end
  endtask

  task automatic test_run_stop();
    int last_a6 = -1;
    int a6_cnt = 0;
    int done_at = -1;
    int rst_seen = 0;
    logic [7:0] e;
    stop_pc = 8'd3; instr_data = 32'h0000_0000; instr_valid = 1'b1;
    pc_exp_q.push_back(8'd1); pc_exp_q.push_back(8'd2); pc_exp_q.push_back(8'd3);
    for (int i = 0; i < 80; i++) begin
      start = 1'b0;
      if (done) begin done_at = i; break; end
      if (hov_reset) rst_seen++;
      if (hov_addr == 10'h040) begin
        if (last_a6 >= 0) begin
          n_cmp++;
          if ((i - last_a6) !== 11) begin
            n_err++;
            $display("FAIL step_len: got %0d cycles want 11", i - last_a6);
          end
        end
        last_a6 = i;
        a6_cnt++;
        if (a6_cnt == 2) start = 1'b1;
      end
      if (hov_addr == 10'h080) begin
        n_cmp++;
        if (pc_exp_q.size() == 0) begin
          n_err++;
          $display("FAIL run_pc: got %h with no expected value left", pc);
        end else begin
          e = pc_exp_q.pop_front();
          if (pc !== e) begin
            n_err++;
            $display("FAIL run_pc: got %h want %h", pc, e);
          end
        end
      end
      @(negedge clk);
    end
    start = 1'b0;
    n_cmp++;
    if (done_at < 0) begin
      n_err++;
      $display("FAIL run_done_timeout: got no done want done within 80 cycles");
      return;
    end
    n_cmp++;
    if ({busy, pc} !== {1'b0, 8'd3} || (done_at - last_a6) !== 4) begin
      n_err++;
      $display("FAIL run_done: got busy=%b pc=%h a6_to_done=%0d want busy=0 pc=03 4",
               busy, pc, done_at - last_a6);
    end
    @(negedge clk);
    n_cmp++;
    if (done !== 1'b0) begin
      n_err++;
      $display("FAIL done_pulse_width: got %b want 0 one cycle later", done);
    end
    n_cmp++;
    if (rst_seen !== 0 || pc_exp_q.size() !== 0) begin
      n_err++;
      $display("FAIL start_ignored_busy: got hov_reset_cycles=%0d pcs_left=%0d want 0 0",
               rst_seen, pc_exp_q.size());
    end
  endtask

  task automatic test_status_out();
    int done_at = -1, exec_at = -1, refill_at = -1, a6_at = -1;
    int in2_extra = 0, ov_cnt = 0;
    bit swapped = 1'b0;
    logic [W-1:0] eo;
    logic [5:0] ew;
    in1_data = 12'h3C5; in2_data = 12'h5A6; in1_valid = 1'b1; in2_valid = 1'b1;
    exec_status = 4'b0101; res_lo = 8'hBC; res_hi = 4'hA;
    stop_pc = 8'd1; instr_valid = 1'b1; out_ready = 1'b1;
    exp_q.push_back({1'b0, 12'hABC});
    wd_q.push_back(6'h1E); wd_q.push_back(6'h1C);
    pulse_start();
    for (int i = 0; i < 80; i++) begin
      if (done) begin done_at = i; break; end
      if (instr_ready && !swapped) begin swapped = 1'b1; in1_data = 12'h71E; end
      if (hov_addr == 10'h020) exec_at = i;
      if (exec_at >= 0 && in1_ready && in1_valid && refill_at < 0) refill_at = i;
      if (exec_at >= 0 && in2_ready) in2_extra++;
      if (exec_at >= 0 && (hov_addr == 10'h040 || hov_addr == 10'h080)) begin
        if (hov_addr == 10'h040) a6_at = i;
        n_cmp++;
        if (wd_q.size() == 0) begin
          n_err++;
          $display("FAIL refill_wdata: got %h with no expected value left", hov_wdata);
        end else begin
          ew = wd_q.pop_front();
          if (hov_wdata !== ew) begin
            n_err++;
            $display("FAIL refill_wdata: addr=%h got %h want %h", hov_addr, hov_wdata, ew);
          end
        end
      end
      if (out_valid && out_ready) begin
        ov_cnt++;
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL out_result: got %h with no expected value left", {out_sel, out_data});
        end else begin
          eo = exp_q.pop_front();
          if ({out_sel, out_data} !== eo) begin
            n_err++;
            $display("FAIL out_result: got sel=%b data=%h want sel=%b data=%h",
                     out_sel, out_data, eo[12], eo[11:0]);
          end
        end
      end
      @(negedge clk);
    end
    n_cmp++;
    if (done_at < 0) begin
      n_err++;
      $display("FAIL status_done_timeout: got no done want done within 80 cycles");
      return;
    end
    n_cmp++;
    if (refill_at < 0 || a6_at < 0 || refill_at >= a6_at || in2_extra !== 0) begin
      n_err++;
      $display("FAIL in1_refill_order: got refill=%0d a6=%0d in2_ready_cycles=%0d want refill before a6, 0",
               refill_at, a6_at, in2_extra);
    end
    n_cmp++;
    if (ov_cnt !== 1 || pc !== 8'd1 || exp_q.size() !== 0 || wd_q.size() !== 0) begin
      n_err++;
      $display("FAIL status_out_totals: got outputs=%0d pc=%h left=%0d/%0d want 1 01 0/0",
               ov_cnt, pc, exp_q.size(), wd_q.size());
    end
  endtask

  task automatic test_push_stall();
    logic [W-1:0] eo;
    exec_status = 4'b1100; res_lo = 8'hE7; res_hi = 4'h5; stop_pc = 8'd1;
    out_ready = 1'b0;
    exp_q.push_back({1'b1, 12'h5E7});
    pulse_start();
    for (int i = 0; i < 60; i++) begin
      if (out_valid) break;
      @(negedge clk);
    end
    n_cmp++;
    if (out_valid !== 1'b1 || pc !== 8'd1) begin
      n_err++;
      $display("FAIL push_reach: got out_valid=%b pc=%h want 1 01", out_valid, pc);
      out_ready = 1'b1;
      return;
    end
    for (int k = 0; k < 5; k++) begin
      n_cmp++;
      if ({out_valid, out_sel, out_data, hov_addr, done} !== {1'b1, 1'b1, 12'h5E7, 10'h000, 1'b0}) begin
        n_err++;
        $display("FAIL push_hold: cycle %0d got valid=%b sel=%b data=%h addr=%h done=%b want 1 1 5e7 000 0",
                 k, out_valid, out_sel, out_data, hov_addr, done);
      end
      @(negedge clk);
    end
    out_ready = 1'b1;
    eo = exp_q.pop_front();
    n_cmp++;
    if ({out_valid, out_sel, out_data} !== {1'b1, eo}) begin
      n_err++;
      $display("FAIL push_result: got valid=%b sel=%b data=%h want 1 %b %h",
               out_valid, out_sel, out_data, eo[12], eo[11:0]);
    end
    @(negedge clk);
    n_cmp++;
    if ({done, busy, out_valid} !== 3'b100) begin
      n_err++;
      $display("FAIL push_done: got done=%b busy=%b out_valid=%b want 1 0 0", done, busy, out_valid);
    end
  endtask

  task automatic test_abort();
    int l2_at = -1, done_at = -1;
    logic prev_busy = 1'b0;
    exec_status = 4'h0; stop_pc = 8'hFF; out_ready = 1'b1;
    pulse_start();
    for (int i = 0; i < 80; i++) begin
      abort = 1'b0;
      if (done) begin done_at = i; break; end
      if (hov_addr == 10'h004 && l2_at < 0) begin l2_at = i; abort = 1'b1; end
      prev_busy = busy;
      @(negedge clk);
    end
    abort = 1'b0;
    n_cmp++;
    if (done_at < 0 || l2_at < 0) begin
      n_err++;
      $display("FAIL abort_timeout: got l2=%0d done=%0d want both seen", l2_at, done_at);
      return;
    end
    n_cmp++;
    if ((done_at - l2_at) !== 8 || {busy, prev_busy, pc} !== {1'b0, 1'b1, 8'd1}) begin
      n_err++;
      $display("FAIL abort_boundary: got l2_to_done=%0d busy=%b busy_before=%b pc=%h want 8 0 1 01",
               done_at - l2_at, busy, prev_busy, pc);
    end
  endtask

  task automatic test_reset_mid();
    int rst_cnt = 0, done_at = -1;
    stop_pc = 8'hFF;
    pulse_start();
    for (int i = 0; i < 60; i++) begin
      if (hov_addr == 10'h020) break;
      @(negedge clk);
    end
    n_cmp++;
    if (hov_addr !== 10'h020) begin
      n_err++;
      $display("FAIL reset_mid_exec: got addr=%h want 020 within 60 cycles", hov_addr);
    end
    #2 reset_n = 1'b0;
    #1;
    n_cmp++;
    if ({busy, done, pc, instr_ready, in1_ready, in2_ready, out_valid, out_sel, out_data,
         hov_reset, hov_addr, hov_wdata, fsm_state} !== 48'd0) begin
      n_err++;
      $display("FAIL reset_mid_async: got busy=%b done=%b pc=%h addr=%h wdata=%h state=%0d want all 0",
               busy, done, pc, hov_addr, hov_wdata, fsm_state);
    end
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    stop_pc = 8'd1;
    pulse_start();
    for (int i = 0; i < 80; i++) begin
      if (hov_reset) rst_cnt++;
      if (done) begin done_at = i; break; end
      @(negedge clk);
    end
    n_cmp++;
    if (done_at < 0 || rst_cnt !== 2 || pc !== 8'd1) begin
      n_err++;
      $display("FAIL rerun_after_reset: got done_at=%0d hov_reset_cycles=%0d pc=%h want done 2 01",
               done_at, rst_cnt, pc);
    end
  endtask

  initial begin
    reset_n = 1'b0; start = 1'b0; abort = 1'b0; stop_pc = 8'hFF;
    instr_data = 32'd0; instr_valid = 1'b0;
    in1_data = 12'd0; in1_valid = 1'b0; in2_data = 12'd0; in2_valid = 1'b0;
    out_ready = 1'b1; exec_status = 4'h0; res_lo = 8'h00; res_hi = 4'h0;
    test_reset();
    test_start_prime();
    test_run_stop();
    test_status_out();
    test_push_stall();
    test_abort();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
